// File: rtl/player_shot_ctrl_pkg.sv
// Shared types and playfield constants for the player/shot control stage.
package player_shot_ctrl_pkg;

    localparam int COORD_W  = 9;

    localparam int X_MIN    = 72;
    localparam int X_MAX    = 216;
    localparam int SHOT_Y0  = 207;
    localparam int PLAYER_Y = 215;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_COOL = 2'd2
    } shot_state_e;

endpackage

// File: rtl/player_shot_ctrl_if.sv
// Frame/switch/hit inputs and sprite-coordinate outputs of the control stage.
interface player_shot_ctrl_if;
    import player_shot_ctrl_pkg::*;

    logic               frame_tick;
    logic               swR;
    logic               swL;
    logic               swF;
    logic               hit;
    logic [COORD_W-1:0] player_X;
    logic [COORD_W-1:0] shot_X;
    logic [COORD_W-1:0] shot_Y;
    logic               shot_active;
    logic               shot_fired;

    modport master (
        output frame_tick, swR, swL, swF, hit,
        input  player_X, shot_X, shot_Y, shot_active, shot_fired
    );

    modport slave (
        input  frame_tick, swR, swL, swF, hit,
        output player_X, shot_X, shot_Y, shot_active, shot_fired
    );

endinterface

// File: rtl/player_shot_ctrl_switch_debounce.sv
// Two-flop synchroniser plus frame-rate debouncer for one raw switch.
module switch_debounce #(
    parameter int DB_FRAMES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_tick,
    input  logic sw_async,
    output logic sw_db
);

    localparam int CNT_W = $clog2(DB_FRAMES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Bring the asynchronous switch into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw_async;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive frame ticks of disagreement; flip after DB_FRAMES of them
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (frame_tick) begin
            if (sync2_q != db_q) begin
                if (cnt_q == CNT_W'(DB_FRAMES - 1)) begin
                    db_d  = ~db_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Debounce state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign sw_db = db_q;

endmodule

// File: rtl/player_shot_ctrl.sv
// Player movement and single-bullet control, updated once per video frame.
module player_shot_ctrl #(
    parameter int X_MIN       = player_shot_ctrl_pkg::X_MIN,
    parameter int X_MAX       = player_shot_ctrl_pkg::X_MAX,
    parameter int X_RESET     = 150,
    parameter int MOVE_STEP   = 2,
    parameter int SHOT_Y0     = player_shot_ctrl_pkg::SHOT_Y0,
    parameter int SHOT_DX     = 2,
    parameter int SHOT_STEP   = 4,
    parameter int DB_FRAMES   = 3,
    parameter int COOL_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    player_shot_ctrl_if.slave  io
);
    import player_shot_ctrl_pkg::*;

    localparam int COOL_W = $clog2(COOL_FRAMES + 1);
    localparam logic [COORD_W:0] XMIN_E = (COORD_W + 1)'(X_MIN);
    localparam logic [COORD_W:0] XMAX_E = (COORD_W + 1)'(X_MAX);
    localparam logic [COORD_W:0] STEP_E = (COORD_W + 1)'(MOVE_STEP);

    logic               db_r;
    logic               db_l;
    logic               db_f;
    logic               fire_prev_q;
    logic               fire_req_q;
    logic               fire_req_d;
    logic [COORD_W-1:0] player_x_q;
    logic [COORD_W-1:0] player_x_d;
    logic [COORD_W-1:0] shot_x_q;
    logic [COORD_W-1:0] shot_x_d;
    logic [COORD_W-1:0] shot_y_q;
    logic [COORD_W-1:0] shot_y_d;
    logic [COOL_W-1:0]  cool_cnt_q;
    logic [COOL_W-1:0]  cool_cnt_d;
    logic               shot_fired_q;
    logic               shot_fired_d;
    logic [COORD_W:0]   px_ext;
    logic [COORD_W:0]   px_right;
    logic [COORD_W:0]   px_left;
    shot_state_e        state_q;
    shot_state_e        state_d;

    switch_debounce #(.DB_FRAMES(DB_FRAMES)) u_db_r (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (io.frame_tick),
        .sw_async   (io.swR),
        .sw_db      (db_r)
    );

    switch_debounce #(.DB_FRAMES(DB_FRAMES)) u_db_l (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (io.frame_tick),
        .sw_async   (io.swL),
        .sw_db      (db_l)
    );

    switch_debounce #(.DB_FRAMES(DB_FRAMES)) u_db_f (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (io.frame_tick),
        .sw_async   (io.swF),
        .sw_db      (db_f)
    );

    // Fire request: set on a debounced rising edge, consumed by every frame tick
    always_comb begin
        fire_req_d = fire_req_q;
        if (io.frame_tick) begin
            fire_req_d = 1'b0;
        end
        if (db_f && !fire_prev_q) begin
            fire_req_d = 1'b1;
        end
    end

    // Horizontal move with 10-bit clamping; both or neither switch holds position
    always_comb begin
        px_ext     = {1'b0, player_x_q};
        px_right   = px_ext + STEP_E;
        px_left    = px_ext - STEP_E;
        player_x_d = player_x_q;
        if (io.frame_tick && (db_r != db_l)) begin
            if (db_r) begin
                player_x_d = (px_right > XMAX_E) ? COORD_W'(XMAX_E) : COORD_W'(px_right);
            end else begin
                player_x_d = (px_ext < XMIN_E + STEP_E) ? COORD_W'(XMIN_E) : COORD_W'(px_left);
            end
        end
    end

    // Shot FSM next state; hit has priority over the frame tick while flying
    always_comb begin
        state_d      = state_q;
        shot_x_d     = shot_x_q;
        shot_y_d     = shot_y_q;
        cool_cnt_d   = cool_cnt_q;
        shot_fired_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io.frame_tick && fire_req_q) begin
                    shot_x_d     = player_x_q + COORD_W'(SHOT_DX);
                    shot_y_d     = COORD_W'(SHOT_Y0);
                    shot_fired_d = 1'b1;
                    state_d      = ST_FLY;
                end
            end
            ST_FLY: begin
                if (io.hit) begin
                    state_d    = ST_COOL;
                    cool_cnt_d = '0;
                end else if (io.frame_tick) begin
                    if (shot_y_q < COORD_W'(SHOT_STEP)) begin
                        state_d    = ST_COOL;
                        cool_cnt_d = '0;
                    end else begin
                        shot_y_d = shot_y_q - COORD_W'(SHOT_STEP);
                    end
                end
            end
            ST_COOL: begin
                if (io.frame_tick) begin
                    if (cool_cnt_q == COOL_W'(COOL_FRAMES - 1)) begin
                        state_d    = ST_IDLE;
                        cool_cnt_d = '0;
                    end else begin
                        cool_cnt_d = cool_cnt_q + COOL_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fire_prev_q  <= 1'b0;
            fire_req_q   <= 1'b0;
            player_x_q   <= COORD_W'(X_RESET);
            shot_x_q     <= '0;
            shot_y_q     <= '0;
            cool_cnt_q   <= '0;
            shot_fired_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fire_prev_q  <= db_f;
            fire_req_q   <= fire_req_d;
            player_x_q   <= player_x_d;
            shot_x_q     <= shot_x_d;
            shot_y_q     <= shot_y_d;
            cool_cnt_q   <= cool_cnt_d;
            shot_fired_q <= shot_fired_d;
        end
    end

    assign io.player_X    = player_x_q;
    assign io.shot_X      = shot_x_q;
    assign io.shot_Y      = shot_y_q;
    assign io.shot_active = (state_q == ST_FLY);
    assign io.shot_fired  = shot_fired_q;

endmodule
